// File: rtl/modred_barrett_pkg.sv
// Shared constants for the Barrett reduction path: DSP tile geometry, the
// Goldilocks modulus with its Barrett constant, and the reducer latency used by
// the butterfly valid/tag delay lines.
package modred_barrett_pkg;

    // Native multiplier tile of the target DSP block.
    localparam int unsigned DSP_W = 24;
    localparam int unsigned DSP_H = 17;

    // Enabled cycles from an accepted sample to its residue on out_r.
    localparam int unsigned DELAY_RED = 4;

    // Goldilocks prime 2^64 - 2^32 + 1 and floor(2^128 / q).
    localparam logic [63:0] GOLD_Q  = 64'd18446744069414584321;
    localparam logic [64:0] GOLD_MU = 65'h1_0000_0000_FFFF_FFFF;

    function automatic int unsigned ceil_div(input int unsigned num, input int unsigned den);
        return (num + den - 1) / den;
    endfunction

endpackage

// File: rtl/modred_barrett_wide_mul.sv
// Registered AW x BW unsigned multiplier built from DSP_W x DSP_H tiles.
// Tile products are aligned to their weight, reduced in carry-save form and
// resolved by a single final adder. The product is kept modulo 2^OW, so OW may
// be set below AW+BW when only the low bits are needed.
module modred_barrett_wide_mul
    import modred_barrett_pkg::*;
#(
    parameter int unsigned AW = 65,
    parameter int unsigned BW = 65,
    parameter int unsigned OW = 130
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [AW-1:0] a,
    input  logic [BW-1:0] b,
    output logic [OW-1:0] p
);

    localparam int unsigned NA  = ceil_div(AW, DSP_W);
    localparam int unsigned NB  = ceil_div(BW, DSP_H);
    localparam int unsigned NPP = NA * NB;
    localparam int unsigned PAW = NA * DSP_W;
    localparam int unsigned PBW = NB * DSP_H;
    // Wide enough for the full product, so every tile shift is lossless before truncation.
    localparam int unsigned PW  = PAW + PBW;

    logic [PAW-1:0] a_pad;
    logic [PBW-1:0] b_pad;
    logic [OW-1:0]  pp [NPP];
    logic [OW-1:0]  prod_d;
    logic [OW-1:0]  prod_q;

    assign a_pad = PAW'(a);
    assign b_pad = PBW'(b);

    for (genvar i = 0; i < NA; i++) begin : g_row
        for (genvar j = 0; j < NB; j++) begin : g_col
            assign pp[i*NB+j] = OW'((PW'(a_pad[i*DSP_W +: DSP_W]) *
                                     PW'(b_pad[j*DSP_H +: DSP_H])) << (i*DSP_W + j*DSP_H));
        end
    end

    // Carry-save reduction of all tile products, then one carry-propagate add.
    always_comb begin
        logic [OW-1:0] s;
        logic [OW-1:0] c;
        logic [OW-1:0] t;
        s = '0;
        c = '0;
        t = '0;
        for (int n = 0; n < NPP; n++) begin
            t = s ^ c ^ pp[n];
            c = ((s & c) | (s & pp[n]) | (c & pp[n])) << 1;
            s = t;
        end
        prod_d = s + c;
    end

    // Output register; holds while the pipeline is stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prod_q <= '0;
        end else if (en) begin
            prod_q <= prod_d;
        end
    end

    assign p = prod_q;

endmodule

// File: rtl/modred_barrett.sv
// Pipelined Barrett reducer: out_r = in_c mod q for in_c < q^2, q a LOGQ-bit
// modulus with its top bit set. Five register ranks give a residue DELAY_RED
// enabled cycles after the sample is accepted; en=0 freezes every rank.
// LOGQ is limited to 64 by the width of the fixed-modulus parameters.
module modred_barrett
    import modred_barrett_pkg::*;
#(
    parameter int unsigned LOGQ       = 64,
    parameter bit          IS_Q_FIXED = 1'b0,
    parameter logic [63:0] Q          = GOLD_Q,
    parameter logic [64:0] MU         = GOLD_MU
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              in_valid,
    input  logic [2*LOGQ-1:0] in_c,
    input  logic [LOGQ-1:0]   q,
    input  logic [LOGQ:0]     mu,
    output logic              out_valid,
    output logic [LOGQ-1:0]   out_r
);

    localparam int unsigned K = LOGQ;

    logic [K-1:0]     q_eff;
    logic [K:0]       mu_eff;

    logic [DELAY_RED:0] vld_q;
    logic [K:0]       q1_q;
    logic [K+1:0]     c1_q;
    logic [K+1:0]     c2_q;
    logic [K+1:0]     c3_q;

    logic [2*K+1:0]   p1;
    logic [K:0]       q3;
    logic [K+1:0]     p2;

    logic [K+1:0]     r_d;
    logic [K+1:0]     r_q;

    logic [K+2:0]     d1;
    logic [K+2:0]     d2;
    logic [K-1:0]     out_r_d;
    logic [K-1:0]     out_r_q;

    logic             unused_bits;

    // Fixed parameters let synthesis fold the constant operands into both multipliers.
    assign q_eff  = IS_Q_FIXED ? Q[K-1:0] : q;
    assign mu_eff = IS_Q_FIXED ? MU[K:0]  : mu;

    // Valid shift chain: bit 0 is S1, the last bit is out_valid. Bubbles shift like data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= '0;
        end else if (en) begin
            vld_q <= {vld_q[DELAY_RED-1:0], in_valid};
        end
    end

    // S1 capture of q1 and the low c bits, plus the c delay line that meets q3*q in S3.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q1_q <= '0;
            c1_q <= '0;
            c2_q <= '0;
            c3_q <= '0;
        end else if (en) begin
            q1_q <= in_c[2*K-1:K-1];
            c1_q <= in_c[K+1:0];
            c2_q <= c1_q;
            c3_q <= c2_q;
        end
    end

    // S2: q1 * mu; only the bits above k+1 form the quotient estimate.
    modred_barrett_wide_mul #(
        .AW (K + 1),
        .BW (K + 1),
        .OW (2 * K + 2)
    ) u_mul_mu (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .a   (q1_q),
        .b   (mu_eff),
        .p   (p1)
    );

    assign q3 = p1[2*K+1:K+1];

    // S2b: q3 * q, needed only modulo 2^(k+2) because the true remainder is below 3q.
    modred_barrett_wide_mul #(
        .AW (K + 1),
        .BW (K),
        .OW (K + 2)
    ) u_mul_q (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .a   (q3),
        .b   (q_eff),
        .p   (p2)
    );

    // Wrapping subtract; the result is exact since 0 <= r < 3q < 2^(k+2).
    assign r_d = c3_q - p2;

    // S3 remainder register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q <= '0;
        end else if (en) begin
            r_q <= r_d;
        end
    end

    // Both corrections computed in parallel; the MSB of each is its borrow.
    assign d1 = {1'b0, r_q} - {3'b000, q_eff};
    assign d2 = {1'b0, r_q} - {2'b00, q_eff, 1'b0};

    // S4 selector: prefer r-2q, then r-q, else r unchanged.
    always_comb begin
        out_r_d = r_q[K-1:0];
        if (!d2[K+2]) begin
            out_r_d = d2[K-1:0];
        end else if (!d1[K+2]) begin
            out_r_d = d1[K-1:0];
        end
    end

    // Output register; cleared by reset so a flushed pipeline shows zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_r_q <= '0;
        end else if (en) begin
            out_r_q <= out_r_d;
        end
    end

    assign out_valid = vld_q[DELAY_RED];
    assign out_r     = out_r_q;

    // Low product bits and the always-zero high difference bits carry no information.
    assign unused_bits = ^{p1[K:0], d1[K+1:K], d2[K+1:K]};

endmodule

// File: tb/tb_modred_barrett.sv
// Bench for modred_barrett: a 64-bit instance fed through the q/mu ports, a
// 64-bit fixed-modulus instance with the ports tied off, and a 14-bit instance
// with q = 12289. A per-cycle model tracks valid slots through stalls.
module tb_modred_barrett;

    localparam logic [63:0] GQ  = 64'hFFFF_FFFF_0000_0001;
    localparam logic [64:0] GMU = 65'h1_0000_0000_FFFF_FFFF;
    localparam logic [13:0] SQ  = 14'd12289;
    localparam logic [14:0] SMU = 15'd21843;  // floor(2^28 / 12289)
    localparam int          DLY = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         en = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_valid14 = 1'b0;
    logic [127:0] in_c = '0;
    logic [27:0]  in_c14 = '0;

    logic         ov_a;
    logic         ov_f;
    logic         ov_s;
    logic [63:0]  r_a;
    logic [63:0]  r_f;
    logic [13:0]  r_s;

    int n_checks = 0;
    int n_fail = 0;

    logic [63:0] cur_exp64 = '0;
    logic [13:0] cur_exp14 = '0;
    logic        vh64 [$];
    logic        vh14 [$];
    logic [63:0] dq64 [$];
    logic [13:0] dq14 [$];
    logic        exp_ov64 = 1'b0;
    logic        exp_ov14 = 1'b0;
    logic [63:0] exp_r64 = '0;
    logic [13:0] exp_r14 = '0;
    logic        en_edge;
    logic        rst_edge;

    always #5 clk = ~clk;

    modred_barrett u_dut_a (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .in_valid  (in_valid),
        .in_c      (in_c),
        .q         (GQ),
        .mu        (GMU),
        .out_valid (ov_a),
        .out_r     (r_a)
    );

    modred_barrett #(
        .IS_Q_FIXED (1'b1)
    ) u_dut_f (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .in_valid  (in_valid),
        .in_c      (in_c),
        .q         (64'h0),
        .mu        (65'h0),
        .out_valid (ov_f),
        .out_r     (r_f)
    );

    modred_barrett #(
        .LOGQ (14)
    ) u_dut_s (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .in_valid  (in_valid14),
        .in_c      (in_c14),
        .q         (SQ),
        .mu        (SMU),
        .out_valid (ov_s),
        .out_r     (r_s)
    );

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Model: record accepted slots on enabled edges, then compare 1 ns later.
    always @(posedge clk) begin
        en_edge  = en;
        rst_edge = rst;
        if (!rst && en) begin
            vh64.push_back(in_valid);
            if (in_valid) dq64.push_back(cur_exp64);
            vh14.push_back(in_valid14);
            if (in_valid14) dq14.push_back(cur_exp14);
        end
        #1;
        if (!rst_edge && !rst) begin
            if (en_edge) begin
                exp_ov64 = 1'b0;
                if (vh64.size() > DLY) exp_ov64 = vh64.pop_front();
                if (exp_ov64) exp_r64 = (dq64.size() != 0) ? dq64.pop_front() : 64'h0;
                exp_ov14 = 1'b0;
                if (vh14.size() > DLY) exp_ov14 = vh14.pop_front();
                if (exp_ov14) exp_r14 = (dq14.size() != 0) ? dq14.pop_front() : 14'h0;
            end
            check_eq("ov_ports", ov_a, exp_ov64);
            check_eq("ov_fixed", ov_f, exp_ov64);
            check_eq("ov_q14", ov_s, exp_ov14);
            if (exp_ov64) begin
                check_eq("r_ports", r_a, exp_r64);
                check_eq("r_fixed", r_f, exp_r64);
            end
            if (exp_ov14) check_eq("r_q14", r_s, exp_r14);
        end
    end

    task automatic drive64(input logic v, input logic [127:0] c, input logic [63:0] e);
        in_valid   = v;
        in_c       = c;
        cur_exp64  = e;
        in_valid14 = 1'b0;
        @(negedge clk);
    endtask

    task automatic drive14(input logic v, input logic [27:0] c, input logic [13:0] e);
        in_valid14 = v;
        in_c14     = c;
        cur_exp14  = e;
        in_valid   = 1'b0;
        @(negedge clk);
    endtask

    // Asynchronous reset: outputs must clear within the same cycle.
    task automatic apply_reset();
        rst = 1'b1;
        vh64.delete();
        dq64.delete();
        vh14.delete();
        dq14.delete();
        exp_ov64 = 1'b0;
        exp_ov14 = 1'b0;
        #1;
        check_eq("rst_ov_ports", ov_a, 0);
        check_eq("rst_ov_fixed", ov_f, 0);
        check_eq("rst_ov_q14", ov_s, 0);
        check_eq("rst_r_ports", r_a, 0);
        check_eq("rst_r_fixed", r_f, 0);
        check_eq("rst_r_q14", r_s, 0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic [127:0] c;
        logic [127:0] prod;
        logic [63:0]  a;
        logic [63:0]  b;
        int           idx;
        int unsigned  sa;
        int unsigned  sb;

        @(negedge clk);
        apply_reset();

        // Directed Goldilocks vectors, back to back.
        drive64(1'b1, 128'd0, 64'd0);
        drive64(1'b1, 128'(GQ), 64'd0);
        drive64(1'b1, 128'(GQ) - 128'd1, 64'hFFFF_FFFF_0000_0000);
        drive64(1'b1, 128'd1 << 64, 64'h0000_0000_FFFF_FFFF);
        c = 128'(GQ - 64'd1) * 128'(GQ - 64'd1);
        drive64(1'b1, c, 64'd1);
        c = 128'(GQ - 64'd1) * 128'd2;
        drive64(1'b1, c, GQ - 64'd2);
        repeat (6) drive64(1'b0, 128'd0, 64'd0);

        // Eight accepted items with stalls early and while results are emerging.
        idx = 0;
        for (int t = 0; t < 13; t++) begin
            if ((t >= 2 && t < 5) || (t >= 8 && t < 10)) begin
                en = 1'b0;
                drive64(1'b1, 128'hDEAD, 64'd0);
            end else begin
                en = 1'b1;
                c = 128'(idx) * 128'(GQ) + 128'(idx + 7);
                drive64(1'b1, c, 64'(idx + 7));
                idx++;
            end
        end
        en = 1'b1;
        repeat (6) drive64(1'b0, 128'd0, 64'd0);

        // Reset with items in flight and one on the output, then one fresh item.
        for (int i = 0; i < 5; i++) drive64(1'b1, 128'(i + 3), 64'(i + 3));
        apply_reset();
        drive64(1'b1, 128'(GQ) + 128'd42, 64'd42);
        repeat (8) drive64(1'b0, 128'd0, 64'd0);

        // Random products with bubbles and random stalls.
        for (int n = 0; n < 10000; n++) begin
            en = ($urandom_range(7) != 0);
            a = {$urandom(), $urandom()};
            b = {$urandom(), $urandom()};
            if (a >= GQ) a = a - GQ;
            if (b >= GQ) b = b - GQ;
            prod = 128'(a) * 128'(b);
            drive64(($urandom_range(3) != 0), prod, 64'(prod % 128'(GQ)));
        end
        en = 1'b1;
        repeat (8) drive64(1'b0, 128'd0, 64'd0);

        // Small runtime modulus q = 12289 at LOGQ = 14.
        drive14(1'b1, 28'd0, 14'd0);
        drive14(1'b1, 28'd12289, 14'd0);
        drive14(1'b1, 28'd150994944, 14'd1);
        drive14(1'b1, 28'd16384, 14'd4095);
        drive14(1'b1, 28'd24576, 14'd12287);
        drive14(1'b1, 28'd12290, 14'd1);
        for (int n = 0; n < 2000; n++) begin
            en = ($urandom_range(7) != 0);
            sa = $urandom_range(12288);
            sb = $urandom_range(12288);
            drive14(($urandom_range(3) != 0), 28'(sa * sb), 14'((sa * sb) % 12289));
        end
        en = 1'b1;
        repeat (8) drive14(1'b0, 28'd0, 14'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
